// File: rtl/regfile_pkg.sv
// Purpose: shared sizing constants and types for the register-file storage stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_WIDTH, NUM_REGS, ADDR_WIDTH, ZERO_REG, reg_data_t, reg_en_t, reg_addr_t.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int ZERO_REG   = 31;

    typedef logic [DATA_WIDTH-1:0] reg_data_t;
    typedef logic [NUM_REGS-1:0]   reg_en_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// Purpose: write/read bundle between the gating/decode stages and the register file.
// Latency: n/a (wiring only).
// Backpressure: none; writes are always accepted, reads are combinational.
// Signals: Enable (one-hot row enables), WriteData, ReadRegister1/2 (selects),
//          ReadData1/2 (row contents), MultiHotErr (sticky enable error).
// Modports: master = gating/decode side, slave = register file.
interface regfile_if;
    import regfile_pkg::*;

    reg_en_t   Enable;
    reg_data_t WriteData;
    reg_addr_t ReadRegister1;
    reg_addr_t ReadRegister2;
    reg_data_t ReadData1;
    reg_data_t ReadData2;
    logic      MultiHotErr;

    modport master (
        output Enable,
        output WriteData,
        output ReadRegister1,
        output ReadRegister2,
        input  ReadData1,
        input  ReadData2,
        input  MultiHotErr
    );

    modport slave (
        input  Enable,
        input  WriteData,
        input  ReadRegister1,
        input  ReadRegister2,
        output ReadData1,
        output ReadData2,
        output MultiHotErr
    );

endinterface

// File: rtl/regfile_row.sv
// Purpose: one register-file row, loaded from dataIn when writeEn is high.
// Latency: one clock edge from writeEn to dataOut.
// Backpressure: none.
// Ports: clk, reset (async active-high, clears row), writeEn, dataIn, dataOut.
module regfile_row
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      writeEn,
    input  reg_data_t dataIn,
    output reg_data_t dataOut
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut <= '0;
        end else if (writeEn) begin
            dataOut <= dataIn;
        end
    end

endmodule

// File: rtl/regfile_array.sv
// Purpose: 32x64 register-file storage with X31 hardwired to zero and a sticky multi-hot enable flag.
// Latency: writes land on the next rising edge; reads are combinational.
// Backpressure: none; every one-hot Enable is written, multi-hot Enable is dropped and flagged.
// Ports: clk, reset (async active-high, clears rows and MultiHotErr), bus (regfile_if.slave).
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through to the read ports.
module regfile_array
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);

    logic      multiHot;
    reg_en_t   rowWrEn;
    reg_data_t rowQ [NUM_REGS];

    // v & (v-1) clears the lowest set bit; anything left means two or more bits were set.
    // The zero row's enable bit participates like any other.
    assign multiHot = |(bus.Enable & (bus.Enable - NUM_REGS'(1)));

    for (genvar i = 0; i < NUM_REGS; i++) begin : gRow
        if (i == ZERO_REG) begin : gZero
            assign rowWrEn[i] = 1'b0;
            assign rowQ[i]    = '0;
        end else begin : gReg
            // All-zero Enable writes nothing; multi-hot suppresses every row.
            assign rowWrEn[i] = bus.Enable[i] & ~multiHot;

            regfile_row uRow (
                .clk     (clk),
                .reset   (reset),
                .writeEn (rowWrEn[i]),
                .dataIn  (bus.WriteData),
                .dataOut (rowQ[i])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.MultiHotErr <= 1'b0;
        end else if (multiHot) begin
            bus.MultiHotErr <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // rowWrEn is already zero for the zero row and under multi-hot, so it doubles
    // as the write-through qualifier.
    always_comb begin
        bus.ReadData1 = rowQ[bus.ReadRegister1];
        bus.ReadData2 = rowQ[bus.ReadRegister2];
        if (rowWrEn[bus.ReadRegister1]) begin
            bus.ReadData1 = bus.WriteData;
        end
        if (rowWrEn[bus.ReadRegister2]) begin
            bus.ReadData2 = bus.WriteData;
        end
    end
`else
    assign bus.ReadData1 = rowQ[bus.ReadRegister1];
    assign bus.ReadData2 = rowQ[bus.ReadRegister2];
`endif

endmodule

// File: tb/tb_regfile_array.sv
// Purpose: directed self-checking bench for regfile_array using an expected-value queue.
// Latency: checks taken 1-2 time units after the rising edge or right after input changes.
// Backpressure: n/a.
module tb_regfile_array;
    import regfile_pkg::*;

    typedef struct {
        string     tag;
        int        port;   // 1 = ReadData1, 2 = ReadData2, 3 = MultiHotErr
        reg_data_t val;
    } exp_t;

    logic      clk;
    logic      reset;
    exp_t      sbQ [$];
    int        nVectors;
    int        nMiscompares;

    regfile_if bus ();

    regfile_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expectVal(input string tag, input int port, input reg_data_t val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        sbQ.push_back(e);
    endtask

    task automatic expectRead(input string tag, input reg_data_t v1, input reg_data_t v2);
        expectVal({tag, "_rd1"}, 1, v1);
        expectVal({tag, "_rd2"}, 2, v2);
    endtask

    // Let combinational reads settle, then compare everything queued.
    task automatic drain();
        exp_t      e;
        reg_data_t obs;
        #1;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            case (e.port)
                1:       obs = bus.ReadData1;
                2:       obs = bus.ReadData2;
                default: obs = {{(DATA_WIDTH-1){1'b0}}, bus.MultiHotErr};
            endcase
            nVectors++;
            assert (obs === e.val) else begin
                nMiscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input int r1, input int r2);
        bus.ReadRegister1 = reg_addr_t'(r1);
        bus.ReadRegister2 = reg_addr_t'(r2);
    endtask

    task automatic writeRow(input int row, input reg_data_t d);
        bus.Enable    = reg_en_t'(1) << row;
        bus.WriteData = d;
        tick();
        bus.Enable    = '0;
    endtask

    initial begin
        reg_data_t sameCycleExp;
        nVectors     = 0;
        nMiscompares = 0;
        reset        = 1'b1;
        bus.Enable   = '0;
        bus.WriteData = '0;
        setRead(0, 1);
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        expectRead("rst0", '0, '0);
        expectVal("rst0_err", 3, '0);
        drain();

        // Basic write/read.
        setRead(5, 6);
        writeRow(5, 64'h0123_4567_89AB_CDEF);
        expectRead("basic", 64'h0123_4567_89AB_CDEF, '0);
        drain();

        // Zero register: never written, never bypassed.
        bus.Enable    = reg_en_t'(1) << ZERO_REG;
        bus.WriteData = '1;
        setRead(5, ZERO_REG);
        expectRead("zero_pre", 64'h0123_4567_89AB_CDEF, '0);
        drain();
        tick();
        bus.Enable = '0;
        expectRead("zero_post", 64'h0123_4567_89AB_CDEF, '0);
        expectVal("zero_err", 3, '0);
        drain();

        // Multi-hot: no row written, sticky flag.
        setRead(3, 4);
        writeRow(3, 64'hAA);
        bus.Enable    = (reg_en_t'(1) << 3) | (reg_en_t'(1) << 4);
        bus.WriteData = 64'h55;
        expectRead("mh_pre", 64'hAA, '0);
        expectVal("mh_pre_err", 3, '0);
        drain();
        tick();
        bus.Enable = '0;
        expectRead("mh_post", 64'hAA, '0);
        expectVal("mh_err", 3, 64'd1);
        drain();
        writeRow(4, 64'h44);
        expectRead("mh_after", 64'hAA, 64'h44);
        expectVal("mh_sticky", 3, 64'd1);
        drain();

        // Multi-hot including the zero row still counts.
        bus.Enable    = (reg_en_t'(1) << ZERO_REG) | (reg_en_t'(1) << 3);
        bus.WriteData = 64'h99;
        tick();
        bus.Enable = '0;
        expectRead("mh_zero", 64'hAA, 64'h44);
        drain();

        // Same-cycle read of the row being written.
`ifdef REGFILE_BYPASS_EN
        sameCycleExp = 64'h77;
`else
        sameCycleExp = '0;
`endif
        setRead(7, 8);
        bus.Enable    = reg_en_t'(1) << 7;
        bus.WriteData = 64'h77;
        expectRead("same_pre", sameCycleExp, '0);
        drain();
        tick();
        bus.Enable = '0;
        expectRead("same_post", 64'h77, '0);
        drain();

        // Back-to-back writes: last one wins.
        setRead(9, 7);
        bus.Enable    = reg_en_t'(1) << 9;
        bus.WriteData = 64'h1;
        tick();
        bus.WriteData = 64'h2;
        tick();
        bus.Enable = '0;
        expectRead("b2b", 64'h2, 64'h77);
        drain();

        // Dual port, same row.
        setRead(10, 10);
        writeRow(10, 64'h1234);
        expectRead("dual", 64'h1234, 64'h1234);
        drain();

        // Mid-cycle asynchronous reset clears everything without a clock edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int r = 0; r < NUM_REGS; r++) begin
            setRead(r, NUM_REGS - 1 - r);
            expectRead($sformatf("rst_row%0d", r), '0, '0);
            drain();
        end
        expectVal("rst_err", 3, '0);
        drain();

        // An edge while reset is held performs no write.
        setRead(12, 10);
        bus.Enable    = reg_en_t'(1) << 12;
        bus.WriteData = 64'hC0DE;
        tick();
        bus.Enable = '0;
        reset = 1'b0;
        expectRead("rst_edge", '0, '0);
        drain();

        // First write after release.
        writeRow(12, 64'hC0FFEE);
        expectRead("post_rst", 64'hC0FFEE, '0);
        expectVal("post_rst_err", 3, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
